aes_dec_scheduler: RTL and testbench

AES_DEC_SCHEDULER -- requirements
Module: aes_dec_scheduler

---
 rtl/aes_dec_scheduler_if.sv | 30 +++
 rtl/aes_dec_scheduler.sv | 110 +++++++++++
 tb/tb_aes_dec_scheduler.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_dec_scheduler_if.sv
// Handshake and core-facing bundle for aes_dec_scheduler.
// The slave modport is the scheduler side; the master modport is the requester/core/consumer side.
interface aes_dec_scheduler_if;
  logic         req0_valid;
  logic [127:0] req0_data;
  logic         req0_ready;
  logic         req1_valid;
  logic [127:0] req1_data;
  logic         req1_ready;
  logic [127:0] core_data;
  logic         core_enable;
  logic         core_restart;
  logic [127:0] core_out;
  logic         resp_valid;
  logic [127:0] resp_data;
  logic         resp_id;
  logic         resp_ready;

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data, core_out, resp_ready,
    output req0_ready, req1_ready, core_data, core_enable, core_restart,
    output resp_valid, resp_data, resp_id
  );

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data, core_out, resp_ready,
    input  req0_ready, req1_ready, core_data, core_enable, core_restart,
    input  resp_valid, resp_data, resp_id
  );
endinterface

// File: rtl/aes_dec_scheduler.sv
// Two-requester front end for an iterative AES decrypt core: arbitrate, load, run LAT cycles,
// hold the plaintext until accepted. Define AES_DEC_SCHED_FIXED_PRIO_EN for fixed priority to req0.
module aes_dec_scheduler #(
  parameter int unsigned Nr  = 10,
  parameter int unsigned LAT = Nr + 2
) (
  input logic                clk,
  input logic                reset,
  aes_dec_scheduler_if.slave bus
);

  localparam int unsigned CntW = $clog2(LAT + 1);
  localparam logic [CntW-1:0] LatCnt = CntW'(LAT);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  logic [1:0]      state_q, state_d;
  logic            rr_q, rr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            resp_id_q, resp_id_d;
  logic [127:0]    resp_data_q, resp_data_d;
  logic [127:0]    core_data_q, core_data_d;
  logic            win;
  logic            ready0, ready1;

  // Winner is only meaningful when at least one requester is valid.
  always_comb begin
    win = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
`ifdef AES_DEC_SCHED_FIXED_PRIO_EN
      win = 1'b0;
`else
      win = rr_q;
`endif
    end else if (bus.req1_valid) begin
      win = 1'b1;
    end
  end

  assign ready0 = (state_q == StIdle) && bus.req0_valid && !win;
  assign ready1 = (state_q == StIdle) && bus.req1_valid && win;

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    resp_id_d   = resp_id_q;
    resp_data_d = resp_data_q;
    core_data_d = core_data_q;
    case (state_q)
      StIdle: begin
        if (ready0 || ready1) begin
          core_data_d = win ? bus.req1_data : bus.req0_data;
          resp_id_d   = win;
          rr_d        = ~win;
          state_d     = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = CntW'(1);
        state_d = StRun;
      end
      StRun: begin
        if (cnt_q == LatCnt) begin
          resp_data_d = bus.core_out;
          state_d     = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (bus.resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      rr_q        <= 1'b0;
      cnt_q       <= '0;
      resp_id_q   <= 1'b0;
      resp_data_q <= '0;
      core_data_q <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      resp_id_q   <= resp_id_d;
      resp_data_q <= resp_data_d;
      core_data_q <= core_data_d;
    end
  end

  assign bus.req0_ready   = ready0;
  assign bus.req1_ready   = ready1;
  assign bus.core_data    = core_data_q;
  assign bus.core_restart = (state_q == StLoad);
  assign bus.core_enable  = (state_q == StLoad) || (state_q == StRun);
  assign bus.resp_valid   = (state_q == StDone);
  assign bus.resp_data    = resp_data_q;
  assign bus.resp_id      = resp_id_q;

endmodule

// File: tb/tb_aes_dec_scheduler.sv
// Self-checking bench for aes_dec_scheduler with a behavioural stand-in for the decrypt core.
module tb_aes_dec_scheduler;
  localparam int unsigned Nr  = 10;
  localparam int unsigned LAT = Nr + 2;
  localparam logic [127:0] CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] DA = 128'h0123456789abcdef_fedcba9876543210;
  localparam logic [127:0] DB = 128'hdeadbeef_cafef00d_12345678_9abcdef0;
  localparam logic [127:0] DC = 128'h55555555_aaaaaaaa_33333333_cccccccc;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  aes_dec_scheduler_if bus();

  aes_dec_scheduler #(.Nr(Nr), .LAT(LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Core stand-in: the known AES-128 vector (key 000102..0f) maps CT->PT, other blocks get an
  // arbitrary bijection; the result is only presented on the cycle it is due.
  function automatic logic [127:0] core_fn(input logic [127:0] c);
    return (c == CT) ? PT : (c ^ {4{32'h5a5a5a5a}});
  endfunction

  logic [127:0] cm_data = '0;
  int unsigned  cm_cnt  = 0;
  always @(posedge clk) begin
    if (bus.core_restart) begin
      cm_data <= bus.core_data;
      cm_cnt  <= 1;
    end else if (bus.core_enable) begin
      cm_cnt <= cm_cnt + 1;
    end
  end
  assign bus.core_out = (cm_cnt == LAT) ? core_fn(cm_data) : ~core_fn(cm_data);

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic         v0;
    logic         v1;
    logic [127:0] d0;
    logic [127:0] d1;
    int           stall;
    logic         exp_id;
  } vec_t;

  task automatic run_txn(input vec_t v, input string tag);
    int           n;
    bit           granted;
    bit           run_ok;
    logic [127:0] exp_data;
    exp_data = core_fn(v.exp_id ? v.d1 : v.d0);
    bus.req0_valid = v.v0;
    bus.req0_data  = v.d0;
    bus.req1_valid = v.v1;
    bus.req1_data  = v.d1;
    bus.resp_ready = (v.stall == 0);
    #1;
    n = 0;
    granted = 0;
    while (!granted && n < 20) begin
      if ((bus.req0_ready && bus.req0_valid) || (bus.req1_ready && bus.req1_valid)) granted = 1;
      else begin
        step();
        #1;
        n++;
      end
    end
    chk({tag, "_granted"}, 128'(granted), 128'(1));
    if (!granted) return;
    chk({tag, "_ready_onehot"}, {bus.req0_ready, bus.req1_ready}, v.exp_id ? 2'b01 : 2'b10);
    step();
    // Drop and scramble requests: the captured block must not follow them.
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data  = ~v.d0;
    bus.req1_data  = ~v.d1;
    #1;
    chk({tag, "_load_restart_en"}, {bus.core_restart, bus.core_enable}, 2'b11);
    chk({tag, "_core_data"}, bus.core_data, v.exp_id ? v.d1 : v.d0);
    n = 1;
    run_ok = 1;
    while (!bus.resp_valid && n < LAT + 10) begin
      step();
      n++;
      if (!bus.resp_valid &&
          (!bus.core_enable || bus.core_restart || bus.req0_ready || bus.req1_ready))
        run_ok = 0;
    end
    chk({tag, "_run_enable"}, 128'(run_ok), 128'(1));
    chk({tag, "_latency"}, 128'(n), 128'(LAT + 2));
    chk({tag, "_resp_data"}, bus.resp_data, exp_data);
    chk({tag, "_resp_id"}, 128'(bus.resp_id), 128'(v.exp_id));
    chk({tag, "_done_enable"}, 128'(bus.core_enable), 128'(0));
    for (int i = 0; i < v.stall; i++) begin
      bus.req0_valid = 1'b1;
      bus.req1_valid = 1'b1;
      bus.req0_data  = DC ^ 128'(i);
      bus.req1_data  = DB ^ 128'(i);
      step();
      chk({tag, "_stall_hold"}, {bus.resp_valid, bus.req0_ready, bus.req1_ready}, 3'b100);
      chk({tag, "_stall_data"}, bus.resp_data, exp_data);
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.resp_ready = 1'b1;
    step();
    chk({tag, "_released"}, 128'(bus.resp_valid), 128'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.resp_ready = 1'b1;
    step();
    step();
  endtask

  vec_t vecs[6];

  initial begin
    logic exp_both_a, exp_both_b;
    bit   no_resp;
    int   grants, restarts;
    int   gcyc[4];
    logic gid[4];
    logic exp_alt[4];
`ifdef AES_DEC_SCHED_FIXED_PRIO_EN
    exp_both_a = 1'b0;
    exp_both_b = 1'b0;
    exp_alt = '{1'b0, 1'b0, 1'b0, 1'b0};
`else
    exp_both_a = 1'b1;
    exp_both_b = 1'b0;
    exp_alt = '{1'b0, 1'b1, 1'b0, 1'b1};
`endif
    vecs[0] = '{1'b1, 1'b0, CT, DB, 0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, DA, DB, 0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, DA, DB, 5, exp_both_a};
    vecs[3] = '{1'b1, 1'b1, DB, DA, 0, exp_both_b};
    vecs[4] = '{1'b0, 1'b1, DA, DC, 0, 1'b1};
    vecs[5] = '{1'b0, 1'b1, DB, DA, 0, 1'b1};

    bus.req0_data = '0;
    bus.req1_data = '0;
    do_reset();
    chk("rst_outputs", {bus.resp_valid, bus.core_enable, bus.core_restart, bus.resp_id}, 4'b0);
    chk("rst_resp_data", bus.resp_data, '0);
    chk("rst_core_data", bus.core_data, '0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // Abort a requester-1 block at RUN counter 4.
    bus.req1_valid = 1'b1;
    bus.req1_data  = DC;
    step();
    bus.req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("abort_outputs", {bus.resp_valid, bus.core_enable, bus.core_restart, bus.resp_id,
                          bus.req0_ready, bus.req1_ready}, 6'b0);
    chk("abort_resp_data", bus.resp_data, '0);
    chk("abort_core_data", bus.core_data, '0);
    no_resp = 1;
    for (int i = 0; i < LAT + 5; i++) begin
      step();
      if (bus.resp_valid) no_resp = 0;
    end
    chk("abort_no_resp", 128'(no_resp), 128'(1));
    run_txn('{1'b1, 1'b1, CT, DB, 0, 1'b0}, "post_abort");

    // Both requesters held valid: grant order and spacing.
    do_reset();
    reset = 1'b0;
    bus.req0_valid = 1'b1;
    bus.req0_data  = CT;
    bus.req1_valid = 1'b1;
    bus.req1_data  = DA;
    grants = 0;
    restarts = 0;
    for (int c = 0; c < 4 * (LAT + 3); c++) begin
      #1;
      if ((bus.req0_ready && bus.req0_valid) || (bus.req1_ready && bus.req1_valid)) begin
        if (grants < 4) begin
          gid[grants]  = bus.req1_ready;
          gcyc[grants] = c;
        end
        grants++;
      end
      if (bus.core_restart) restarts++;
      step();
    end
    chk("cont_grants", 128'(grants), 128'(4));
    chk("cont_restarts", 128'(restarts), 128'(grants));
    for (int i = 0; i < 4 && i < grants; i++) begin
      chk($sformatf("cont_id%0d", i), 128'(gid[i]), 128'(exp_alt[i]));
      if (i > 0) chk($sformatf("cont_gap%0d", i), 128'(gcyc[i] - gcyc[i-1]), 128'(LAT + 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
